// File: rtl/vga_ram2port_be.sv
// Simple-dual-port VGA frame-buffer RAM: byte-enabled write port, pipelined read port.
// Optional post-reset zero-fill sequencer compiled in with `define VGA_RAM_CLEAR_EN.
module vga_ram2port_be #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 14,
    parameter int DEPTH    = 9600,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     wraddress,
    input  logic [DATA_W-1:0]     data,
    input  logic [DATA_W/8-1:0]   byteena,
    input  logic                  wren,
    input  logic [ADDR_W-1:0]     rdaddress,
    input  logic                  rden,
    output logic [DATA_W-1:0]     q,
    output logic                  q_valid,
    output logic                  busy
);

    localparam int unsigned NB      = DATA_W / 8;
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_active;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_fire;
    logic              rd_fire;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_wbe;
    logic [DATA_W-1:0] rd_word_d;
    logic [DATA_W-1:0] q_q;
    logic              q_valid_q;

`ifdef VGA_RAM_CLEAR_EN
    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } clr_state_e;

    clr_state_e        state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    assign clr_active = busy_q;
`else
    assign clr_active = 1'b0;
`endif

    assign busy        = clr_active;
    assign wr_in_range = {1'b0, wraddress} < DEPTH_X;
    assign rd_in_range = {1'b0, rdaddress} < DEPTH_X;
    assign wr_fire     = wren && rst_n && !clr_active && wr_in_range;
    assign rd_fire     = rden && rst_n && !clr_active;

    // The clear sequencer borrows the single write port while busy.
    always_comb begin
        mem_we    = wr_fire;
        mem_waddr = wraddress[IDX_W-1:0];
        mem_wdata = data;
        mem_wbe   = byteena;
`ifdef VGA_RAM_CLEAR_EN
        if (rst_n && clr_active) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q[IDX_W-1:0];
            mem_wdata = '0;
            mem_wbe   = '1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Array read sees pre-edge contents; write-first bypass merges the enabled lanes.
    always_comb begin
        rd_word_d = '0;
        if (rd_in_range) begin
            rd_word_d = mem[rdaddress[IDX_W-1:0]];
            if ((WR_FIRST != 0) && wr_fire && (wraddress == rdaddress)) begin
                for (int unsigned k = 0; k < NB; k++) begin
                    if (byteena[k]) begin
                        rd_word_d[8*k +: 8] = data[8*k +: 8];
                    end
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s1_data_q;
            logic              s1_valid_q;

            always_ff @(posedge clock) begin
                if (!rst_n) begin
                    s1_data_q  <= '0;
                    s1_valid_q <= 1'b0;
                    q_q        <= '0;
                    q_valid_q  <= 1'b0;
                end else begin
                    s1_valid_q <= rd_fire;
                    if (rd_fire) begin
                        s1_data_q <= rd_word_d;
                    end
                    q_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        q_q <= s1_data_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clock) begin
                if (!rst_n) begin
                    q_q       <= '0;
                    q_valid_q <= 1'b0;
                end else begin
                    q_valid_q <= rd_fire;
                    if (rd_fire) begin
                        q_q <= rd_word_d;
                    end
                end
            end
        end
    endgenerate

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_vga_ram2port_be.sv
// Scoreboard bench for vga_ram2port_be: two instances (RD_LAT=1/read-old, RD_LAT=2/write-first)
// share one stimulus stream; the clear-sequencer scenario runs when VGA_RAM_CLEAR_EN is defined.
module tb_vga_ram2port_be;

    localparam int DW    = 32;
    localparam int AW    = 14;
    localparam int DEPTH = 9600;
`ifdef VGA_RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rst_n;
    logic [AW-1:0] wraddress;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] data;
    logic [3:0]    byteena;
    logic          wren;
    logic          rden;
    logic [DW-1:0] q_a, q_b;
    logic          qv_a, qv_b;
    logic          busy_a, busy_b;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    exp_t          sb_a[$];
    exp_t          sb_b[$];
    exp_t          ea, eb;
    logic [DW-1:0] model [DEPTH];

    vga_ram2port_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1), .WR_FIRST(0)) dut_a (
        .clock(clock), .rst_n(rst_n), .wraddress(wraddress), .data(data), .byteena(byteena),
        .wren(wren), .rdaddress(rdaddress), .rden(rden), .q(q_a), .q_valid(qv_a), .busy(busy_a)
    );

    vga_ram2port_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2), .WR_FIRST(1)) dut_b (
        .clock(clock), .rst_n(rst_n), .wraddress(wraddress), .data(data), .byteena(byteena),
        .wren(wren), .rdaddress(rdaddress), .rden(rden), .q(q_b), .q_valid(qv_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (mon_en) begin
            if (sb_a.size() != 0 && sb_a[0].due < cyc) begin
                ea = sb_a.pop_front();
                checks++; errors++;
                $display("FAIL lat1_missed: response due cycle %0d never seen, expected q=%h", ea.due, ea.data);
            end
            if (sb_a.size() != 0 && sb_a[0].due == cyc) begin
                ea = sb_a.pop_front();
                checks++;
                if (qv_a !== 1'b1 || q_a !== ea.data) begin
                    errors++;
                    $display("FAIL lat1_read: cycle %0d q=%h q_valid=%b, expected q=%h q_valid=1", cyc, q_a, qv_a, ea.data);
                end
            end else begin
                checks++;
                if (qv_a !== 1'b0) begin
                    errors++;
                    $display("FAIL lat1_idle: cycle %0d q_valid=%b, expected 0", cyc, qv_a);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            if (sb_b.size() != 0 && sb_b[0].due < cyc) begin
                eb = sb_b.pop_front();
                checks++; errors++;
                $display("FAIL lat2_missed: response due cycle %0d never seen, expected q=%h", eb.due, eb.data);
            end
            if (sb_b.size() != 0 && sb_b[0].due == cyc) begin
                eb = sb_b.pop_front();
                checks++;
                if (qv_b !== 1'b1 || q_b !== eb.data) begin
                    errors++;
                    $display("FAIL lat2_read: cycle %0d q=%h q_valid=%b, expected q=%h q_valid=1", cyc, q_b, qv_b, eb.data);
                end
            end else begin
                checks++;
                if (qv_b !== 1'b0) begin
                    errors++;
                    $display("FAIL lat2_idle: cycle %0d q_valid=%b, expected 0", cyc, qv_b);
                end
            end
        end
    end

    // One clock of stimulus; the expected read result is taken from the model before this cycle's write.
    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [3:0] be, input bit re, input logic [AW-1:0] ra);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        @(negedge clock); #1;
        wren = we; wraddress = wa; data = wd; byteena = be; rden = re; rdaddress = ra;
        if (re) begin
            old_w = (int'(ra) < DEPTH) ? model[ra] : '0;
            new_w = old_w;
            if (we && wa == ra && int'(wa) < DEPTH) begin
                for (int k = 0; k < 4; k++) if (be[k]) new_w[8*k +: 8] = wd[8*k +: 8];
            end
            sb_a.push_back('{old_w, cyc + 1});
            sb_b.push_back('{new_w, cyc + 2});
        end
        if (we && int'(wa) < DEPTH) begin
            for (int k = 0; k < 4; k++) if (be[k]) model[wa][8*k +: 8] = wd[8*k +: 8];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic assert_reset;
        @(negedge clock); #1;
        rst_n = 1'b0;
        wren = 1'b1; wraddress = 14'd5; data = 32'hFFFF_FFFF; byteena = 4'hF;
        rden = 1'b1; rdaddress = 14'd5;
        sb_a.delete();
        sb_b.delete();
        repeat (2) @(negedge clock);
        checks++;
        if (q_a !== '0 || qv_a !== 1'b0) begin
            errors++; $display("FAIL reset_a: q=%h q_valid=%b, expected 0/0", q_a, qv_a);
        end
        checks++;
        if (q_b !== '0 || qv_b !== 1'b0) begin
            errors++; $display("FAIL reset_b: q=%h q_valid=%b, expected 0/0", q_b, qv_b);
        end
        checks++;
        if (busy_a !== CLR || busy_b !== CLR) begin
            errors++; $display("FAIL reset_busy: busy=%b/%b, expected %b", busy_a, busy_b, CLR);
        end
    endtask

    task automatic release_reset;
        int n;
        @(negedge clock); #1;
        rst_n = 1'b1; wren = 1'b0; rden = 1'b0;
        if (CLR) begin
            n = 0;
            while (busy_a === 1'b1 && n < DEPTH + 20) begin
                n++;
                @(negedge clock);
            end
            checks++;
            if (n != DEPTH) begin
                errors++; $display("FAIL clear_len: busy high %0d cycles, expected %0d", n, DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL busy_idle: busy=%b/%b, expected 0", busy_a, busy_b);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wren = 1'b0; rden = 1'b0;
        wraddress = '0; rdaddress = '0; data = '0; byteena = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (q_a !== '0 || qv_a !== 1'b0 || q_b !== '0 || qv_b !== 1'b0) begin
            errors++; $display("FAIL por_outputs: q=%h/%h q_valid=%b/%b, expected 0", q_a, q_b, qv_a, qv_b);
        end
        checks++;
        if (busy_a !== CLR) begin
            errors++; $display("FAIL por_busy: busy=%b, expected %b", busy_a, CLR);
        end
        mon_en = 1'b1;
        release_reset();
    endtask

    task automatic test_full_write;
        drive(1'b1, 14'd5, 32'hDEAD_BEEF, 4'hF, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd5);
        idle(3);
    endtask

    task automatic test_byte_enable;
        drive(1'b1, 14'd5, 32'h1122_3344, 4'b0101, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd5);
        drive(1'b1, 14'd5, 32'h0000_0000, 4'b0000, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd5);
        idle(3);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(i), DW'(i), 4'hF, 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(3);
    endtask

    task automatic test_collision;
        drive(1'b1, 14'd7, 32'hAAAA_AAAA, 4'hF, 1'b0, '0);
        drive(1'b1, 14'd7, 32'h5555_5555, 4'hF, 1'b1, 14'd7);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd7);
        drive(1'b1, 14'd7, 32'h1234_5678, 4'b0011, 1'b1, 14'd7);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd7);
        idle(3);
    endtask

    task automatic test_boundary;
        drive(1'b1, 14'd9599, 32'hCAFE_F00D, 4'hF, 1'b0, '0);
        drive(1'b1, 14'd9600, 32'h0BAD_0BAD, 4'hF, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd9599);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd9600);
        drive(1'b1, 14'd16383, 32'h7777_7777, 4'hF, 1'b1, 14'd16383);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd0);
        idle(3);
    endtask

    task automatic test_reset_inflight;
        drive(1'b0, '0, '0, '0, 1'b1, 14'd5);
        assert_reset();
        release_reset();
        idle(4);
        drive(1'b0, '0, '0, '0, 1'b1, 14'd5);
        idle(3);
    endtask

    task automatic test_random;
        for (int i = 0; i < 32; i++) drive(1'b1, AW'(i), $urandom, 4'hF, 1'b0, '0);
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)));
        end
        idle(3);
    endtask

    task automatic test_clear;
        int n;
        if (CLR) begin
            for (int i = 0; i < 16; i++) drive(1'b1, AW'(i), 32'hFFFF_FFFF, 4'hF, 1'b0, '0);
            idle(1);
            assert_reset();
            @(negedge clock); #1;
            rst_n = 1'b1;
            wren = 1'b1; wraddress = 14'd3; data = 32'h1234_5678; byteena = 4'hF;
            rden = 1'b1; rdaddress = 14'd3;
            n = 0;
            while (busy_a === 1'b1 && n < DEPTH + 20) begin
                n++;
                @(negedge clock);
            end
            wren = 1'b0; rden = 1'b0;
            checks++;
            if (n != DEPTH) begin
                errors++; $display("FAIL clear_busy_window: busy high %0d cycles, expected %0d", n, DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            for (int i = 0; i < 16; i++) drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            idle(3);
            assert_reset();
            @(negedge clock); #1;
            rst_n = 1'b1; wren = 1'b0; rden = 1'b0;
            repeat (8) @(negedge clock);
            assert_reset();
            release_reset();
            drive(1'b0, '0, '0, '0, 1'b1, 14'd9599);
            idle(3);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_full_write();
        test_byte_enable();
        test_back_to_back();
        test_collision();
        test_boundary();
        test_reset_inflight();
        test_random();
        test_clear();
        idle(4);
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            errors++; $display("FAIL drain: %0d/%0d responses outstanding, expected 0", sb_a.size(), sb_b.size());
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_ram2port_be.md
Name: vga_ram2port_be

Overview:
- Parametrised simple-dual-port frame-buffer memory for the VGA path: one write port (CPU/drawing side), one read port (pixel-fetch side), one clock.
- Generalises the fixed 32-bit, 14-bit-address frame buffer with:
  - configurable word width and depth;
  - per-byte write enables;
  - a configurable read pipeline with a valid flag;
  - a selectable read/write collision policy;
  - an optional post-reset memory clear sequencer.
- Sits between the drawing engine and the VGA scan-out controller.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8; NB = DATA_W/8 byte lanes.
- ADDR_W, 14: word address width.
- DEPTH, 9600: number of words (38400 bytes at 32 bits); DEPTH <= 2**ADDR_W.
- RD_LAT, 1: read latency in cycles, 1 or 2.
- WR_FIRST, 0: collision policy. 1 = same-address read returns newly written data; 0 = returns old data.

Ports:
- clock, in, 1: single clock; all logic on rising edge.
- rst_n, in, 1: synchronous active-low reset.
- wraddress, in, ADDR_W: write word address.
- data, in, DATA_W: write data; byte k = data[8k+7:8k].
- byteena, in, NB: per-byte write enable.
- wren, in, 1: write request.
- rdaddress, in, ADDR_W: read word address.
- rden, in, 1: read request.
- q, out, DATA_W: read data, registered.
- q_valid, out, 1: q carries the response to a rden issued RD_LAT cycles earlier.
- busy, out, 1: clear in progress (optional feature); tied to 0 when the feature is compiled out.

Behaviour:
- Storage: array mem[0..DEPTH-1] of DATA_W bits. Contents are not reset and are X after power-up unless cleared.
- Write:
  - Occurs at a rising edge when wren=1, rst_n=1 and busy=0.
  - Each byte k with byteena[k]=1 is updated; other bytes keep their value.
  - byteena=0 makes the write a no-op.
  - wraddress >= DEPTH: write silently dropped; no wrap-around.
- Read:
  - rden=1 samples rdaddress at edge N.
  - q and q_valid update at edge N+RD_LAT-1, so they are visible during the cycle after that edge.
  - RD_LAT=1: a single output register.
  - RD_LAT=2: one extra data+valid pipeline stage; back-to-back reads are fully pipelined at one per cycle.
  - rdaddress >= DEPTH returns all-zeros with q_valid=1.
  - When no response is delivered, q holds its previous value and q_valid=0.
- Collision (rden and wren in the same cycle to the same valid address):
  - WR_FIRST=1: q = old word with the enabled bytes replaced by data.
  - WR_FIRST=0: q = old word.
  - The memory is updated in both cases.
- Reset (rst_n=0 at an edge):
  - q=0, q_valid=0, all pipeline stages cleared.
  - In-flight reads are discarded, not delivered.
  - wren and rden are ignored while rst_n=0.
  - Memory is untouched (see optional feature).
- Reset values of outputs: q=0; q_valid=0; busy=0 without the feature, busy=1 with it.

Optional Feature:
- Macro: VGA_RAM_CLEAR_EN.
- When defined, a 2-state FSM (CLEAR, IDLE) with an ADDR_W-bit counter is added.
  - Reset forces state CLEAR, counter=0, busy=1.
  - In CLEAR, one word per cycle is written to all-zeros at mem[counter], and the counter increments.
  - After writing DEPTH-1, the FSM goes to IDLE and busy=0 on the next cycle. The clear takes exactly DEPTH cycles after rst_n rises.
  - While busy: wren is ignored, and rden is ignored (no q_valid).
  - Reset asserted mid-clear restarts the clear from address 0.
- When not defined: no FSM, busy is constant 0, and memory is usable on the first cycle after reset.

Test Plan:
- Write 0xDEADBEEF to addr 5 with byteena=4'hF, then rden addr 5 → after RD_LAT cycles q=0xDEADBEEF, q_valid=1 for exactly one cycle.
- Starting from 0xDEADBEEF at addr 5, write 0x11223344 with byteena=4'b0101 → read addr 5 returns 0xDE22BE44.
- RD_LAT=2: rden to addrs 0,1,2,3 on consecutive cycles, each preloaded with its own index → q=0,1,2,3 on consecutive cycles starting 2 cycles after the first rden, with q_valid continuously high.
- Collision on addr 7: old 0xAAAAAAAA, write 0x55555555 with byteena=F and read in the same cycle → q=0xAAAAAAAA when WR_FIRST=0, q=0x55555555 when WR_FIRST=1. A follow-up read returns 0x55555555 in both cases.
- Boundary: write to addr DEPTH (9600), then read addr 9599 and addr 9600 → addr 9599 unchanged, addr 9600 read returns 0, no X on q. Pulse rst_n low with a read in flight → q=0, q_valid=0, no late valid.
- VGA_RAM_CLEAR_EN with DEPTH=16: fill memory with 0xFF, then reset → busy=1 for exactly 16 cycles, wren ignored during that window, every address reads 0 afterwards. A reset at cycle 8 of the clear restarts the 16-cycle count.
